md_issue_sequencer: RTL



---
 rtl/md_pkg.sv | 18 +
 rtl/md_issue_sequencer_if.sv | 39 +++
 rtl/md_timeout_counter.sv | 25 ++
 rtl/md_issue_sequencer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the mult/div issue sequencer.
//   - md_state_e           : sequencer state encoding
//   - *_DEF localparams    : default timeout, status register index, exception codes
package md_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2,
        StWb    = 2'd3
    } md_state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 64;
    localparam int unsigned RSTATUS_REG_DEF    = 30;
    localparam int unsigned MULT_EXC_CODE_DEF  = 4;
    localparam int unsigned DIV_EXC_CODE_DEF   = 5;

endpackage

// File: rtl/md_issue_sequencer_if.sv
// md_issue_sequencer_if: bundles the core-side decode inputs, the mult/div unit
// handshake and the regfile write-back path of the issue sequencer.
//   master : sequencer side (drives stall, md_operandA/B, md_ctrl_*, wb_*, busy)
//   slave  : core / mult-div unit side (drives op_*, md_result, md_exception, md_resultRDY)
interface md_issue_sequencer_if;

    logic        op_valid;
    logic        op_is_div;
    logic [4:0]  op_rd;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        busy;

    modport master (
        input  op_valid, op_is_div, op_rd, op_a, op_b,
        input  md_result, md_exception, md_resultRDY,
        output stall, md_operandA, md_operandB, md_ctrl_mult, md_ctrl_div,
        output wb_en, wb_reg, wb_data, busy
    );

    modport slave (
        output op_valid, op_is_div, op_rd, op_a, op_b,
        output md_result, md_exception, md_resultRDY,
        input  stall, md_operandA, md_operandB, md_ctrl_mult, md_ctrl_div,
        input  wb_en, wb_reg, wb_data, busy
    );

endinterface

// File: rtl/md_timeout_counter.sv
// md_timeout_counter: saturating up-counter with synchronous clear and enable.
//   clock, reset : clock and synchronous active-high reset
//   clr          : zero the count (wins over en)
//   en           : increment, holding at all-ones
//   count        : current value, width clog2(MaxCount+1)
module md_timeout_counter #(
    parameter int unsigned MaxCount = 64,
    localparam int unsigned Width   = $clog2(MaxCount + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [Width-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/md_issue_sequencer.sv
// md_issue_sequencer: stalls the core on a mul/div, latches operands, pulses the
// unit's start control, waits for the result and issues one write-back cycle.
// Exceptions are written to RSTATUS_REG instead of rd.
//   clock, reset : clock and synchronous active-high reset
//   bus          : md_issue_sequencer_if.master (decode, unit handshake, write-back)
// Build option: MD_TIMEOUT_EN adds a WAIT watchdog that aborts after TIMEOUT_CYCLES.
module md_issue_sequencer
    import md_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned RSTATUS_REG    = RSTATUS_REG_DEF,
    parameter int unsigned MULT_EXC_CODE  = MULT_EXC_CODE_DEF,
    parameter int unsigned DIV_EXC_CODE   = DIV_EXC_CODE_DEF
) (
    input logic                 clock,
    input logic                 reset,
    md_issue_sequencer_if.master bus
);

    md_state_e   state_q;
    logic        is_div_q;
    logic [4:0]  rd_q;
    logic [31:0] operand_a_q;
    logic [31:0] operand_b_q;
    logic        ctrl_mult_q;
    logic        ctrl_div_q;
    logic        wb_en_q;
    logic [4:0]  wb_reg_q;
    logic [31:0] wb_data_q;
    logic        timeout_hit;
    logic [31:0] exc_code;

    assign exc_code = is_div_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);

`ifdef MD_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] wait_cnt;

    md_timeout_counter #(
        .MaxCount (TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .clock (clock),
        .reset (reset),
        .clr   (state_q == StStart),
        .en    (state_q == StWait),
        .count (wait_cnt)
    );

    // Counter reaches TIMEOUT_CYCLES on this edge, i.e. this is the last WAIT cycle.
    assign timeout_hit = (wait_cnt == CntW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            is_div_q    <= 1'b0;
            rd_q        <= '0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
        end else begin
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_en_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.op_valid) begin
                        operand_a_q <= bus.op_a;
                        operand_b_q <= bus.op_b;
                        rd_q        <= bus.op_rd;
                        is_div_q    <= bus.op_is_div;
                        // Pulse is registered so it is high for the START cycle only.
                        ctrl_mult_q <= ~bus.op_is_div;
                        ctrl_div_q  <= bus.op_is_div;
                        state_q     <= StStart;
                    end
                end
                StStart: state_q <= StWait;
                StWait: begin
                    if (bus.md_resultRDY) begin
                        state_q <= StWb;
                        if (bus.md_exception) begin
                            wb_en_q   <= 1'b1;
                            wb_reg_q  <= 5'(RSTATUS_REG);
                            wb_data_q <= exc_code;
                        end else begin
                            wb_en_q   <= (rd_q != 5'd0);
                            wb_reg_q  <= rd_q;
                            wb_data_q <= bus.md_result;
                        end
                    end else if (timeout_hit) begin
                        state_q   <= StWb;
                        wb_en_q   <= 1'b1;
                        wb_reg_q  <= 5'(RSTATUS_REG);
                        wb_data_q <= exc_code;
                    end
                end
                StWb: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // In IDLE the stall follows decode directly so the PC never passes a mul/div.
    assign bus.stall        = (state_q == StIdle) ? bus.op_valid : (state_q != StWb);
    assign bus.busy         = (state_q != StIdle);
    assign bus.md_operandA  = operand_a_q;
    assign bus.md_operandB  = operand_b_q;
    assign bus.md_ctrl_mult = ctrl_mult_q;
    assign bus.md_ctrl_div  = ctrl_div_q;
    assign bus.wb_en        = wb_en_q;
    assign bus.wb_reg       = wb_reg_q;
    assign bus.wb_data      = wb_data_q;

endmodule
